// File: rtl/intersection_controller.sv
// Two-direction intersection sequencer with all-red clearance and pedestrian walk service.
// Optional flashing-yellow mode is compiled in when INTERSECTION_FLASH_EN is defined.
module intersection_controller #(
    parameter int CLEAR_TIME  = 4,
    parameter int GREEN_TIME  = 20,
    parameter int MIN_GREEN   = 8,
    parameter int YELLOW_TIME = 7,
    parameter int WALK_TIME   = 6,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic ped_req_ns,
    input  logic ped_req_ew,
`ifdef INTERSECTION_FLASH_EN
    input  logic flash_req,
`endif
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk_ns,
    output logic walk_ew,
    output logic ped_ack_ns,
    output logic ped_ack_ew
);

    typedef enum logic [2:0] {
        S_CLR_NS,
        S_NS_GREEN,
        S_NS_YELLOW,
        S_CLR_EW,
        S_EW_GREEN,
`ifdef INTERSECTION_FLASH_EN
        S_EW_YELLOW,
        S_FLASH
`else
        S_EW_YELLOW
`endif
    } state_t;

    localparam logic [CNT_W-1:0] LP_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CLR_LAST    = CNT_W'(CLEAR_TIME - 1);
    localparam logic [CNT_W-1:0] LP_GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] LP_MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LP_YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] LP_WALK        = CNT_W'(WALK_TIME);

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] LP_ALL_RED   = 6'b100_100;
    localparam logic [5:0] LP_NS_GREEN  = 6'b001_100;
    localparam logic [5:0] LP_NS_YELLOW = 6'b010_100;
    localparam logic [5:0] LP_EW_GREEN  = 6'b100_001;
    localparam logic [5:0] LP_EW_YELLOW = 6'b100_010;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_pendNs;
    logic             r_pendEw;
    logic             w_pendNsNext;
    logic             w_pendEwNext;
    logic             r_walkNs;
    logic             r_walkEw;
    logic             w_walkNsNext;
    logic             w_walkEwNext;
    logic             r_ackNs;
    logic             r_ackEw;
    logic             w_walkStartNs;
    logic             w_walkStartEw;
    logic [5:0]       r_lamps;
    logic [5:0]       w_lampsNext;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_CLR_NS;
            r_cnt    <= '0;
            r_pendNs <= 1'b0;
            r_pendEw <= 1'b0;
            r_walkNs <= 1'b0;
            r_walkEw <= 1'b0;
            r_ackNs  <= 1'b0;
            r_ackEw  <= 1'b0;
            r_lamps  <= LP_ALL_RED;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_pendNs <= w_pendNsNext;
            r_pendEw <= w_pendEwNext;
            r_walkNs <= w_walkNsNext;
            r_walkEw <= w_walkEwNext;
            r_ackNs  <= w_walkStartNs;
            r_ackEw  <= w_walkStartEw;
            r_lamps  <= w_lampsNext;
        end
    end

    // A green is cut short once the opposite crossing is waiting and the minimum has elapsed.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (enable) begin
            w_cntNext = r_cnt + LP_ONE;
            case (r_state)
                S_CLR_NS:    if (r_cnt == LP_CLR_LAST) w_stateNext = S_NS_GREEN;
                S_NS_GREEN:  if (r_cnt == LP_GREEN_LAST || (r_pendEw && r_cnt >= LP_MIN_LAST))
                                 w_stateNext = S_NS_YELLOW;
                S_NS_YELLOW: if (r_cnt == LP_YELLOW_LAST) w_stateNext = S_CLR_EW;
                S_CLR_EW:    if (r_cnt == LP_CLR_LAST) w_stateNext = S_EW_GREEN;
                S_EW_GREEN:  if (r_cnt == LP_GREEN_LAST || (r_pendNs && r_cnt >= LP_MIN_LAST))
                                 w_stateNext = S_EW_YELLOW;
                S_EW_YELLOW: if (r_cnt == LP_YELLOW_LAST) w_stateNext = S_CLR_NS;
`ifdef INTERSECTION_FLASH_EN
                S_FLASH:     if (!flash_req) w_stateNext = S_CLR_NS;
`endif
                default:     w_stateNext = S_CLR_NS;
            endcase
`ifdef INTERSECTION_FLASH_EN
            if (flash_req) w_stateNext = S_FLASH;
`endif
            if (w_stateNext != r_state) w_cntNext = '0;
        end
    end

    always_comb begin
        w_walkStartNs = enable && (r_state != S_NS_GREEN) && (w_stateNext == S_NS_GREEN)
                        && (r_pendNs || ped_req_ns);
        w_walkStartEw = enable && (r_state != S_EW_GREEN) && (w_stateNext == S_EW_GREEN)
                        && (r_pendEw || ped_req_ew);
        w_pendNsNext  = w_walkStartNs ? 1'b0 : (r_pendNs | ped_req_ns);
        w_pendEwNext  = w_walkStartEw ? 1'b0 : (r_pendEw | ped_req_ew);
`ifdef INTERSECTION_FLASH_EN
        if (r_state == S_FLASH) begin
            w_pendNsNext = r_pendNs;
            w_pendEwNext = r_pendEw;
        end
`endif
        w_walkNsNext = r_walkNs;
        w_walkEwNext = r_walkEw;
        if (enable) begin
            w_walkNsNext = w_walkStartNs
                           || (r_walkNs && (w_stateNext == S_NS_GREEN) && (w_cntNext < LP_WALK));
            w_walkEwNext = w_walkStartEw
                           || (r_walkEw && (w_stateNext == S_EW_GREEN) && (w_cntNext < LP_WALK));
        end
    end

    // Lamps are registered from the upcoming state so they line up with the state register.
    always_comb begin
        w_lampsNext = LP_ALL_RED;
        case (w_stateNext)
            S_NS_GREEN:  w_lampsNext = LP_NS_GREEN;
            S_NS_YELLOW: w_lampsNext = LP_NS_YELLOW;
            S_EW_GREEN:  w_lampsNext = LP_EW_GREEN;
            S_EW_YELLOW: w_lampsNext = LP_EW_YELLOW;
`ifdef INTERSECTION_FLASH_EN
            S_FLASH:     w_lampsNext = {1'b0, ~w_cntNext[2], 2'b00, ~w_cntNext[2], 1'b0};
`endif
            default:     w_lampsNext = LP_ALL_RED;
        endcase
    end

    assign ns_red     = r_lamps[5];
    assign ns_yellow  = r_lamps[4];
    assign ns_green   = r_lamps[3];
    assign ew_red     = r_lamps[2];
    assign ew_yellow  = r_lamps[1];
    assign ew_green   = r_lamps[0];
    assign walk_ns    = r_walkNs;
    assign walk_ew    = r_walkEw;
    assign ped_ack_ns = r_ackNs;
    assign ped_ack_ew = r_ackEw;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed self-checking bench for intersection_controller (default parameters).
// Exercises the flash mode too when INTERSECTION_FLASH_EN is defined.
module tb_intersection_controller;

    localparam logic [5:0] ALL_RED   = 6'b100_100;
    localparam logic [5:0] NS_GREEN  = 6'b001_100;
    localparam logic [5:0] NS_YELLOW = 6'b010_100;
    localparam logic [5:0] EW_GREEN  = 6'b100_001;
    localparam logic [5:0] EW_YELLOW = 6'b100_010;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic ped_req_ns = 1'b0;
    logic ped_req_ew = 1'b0;
`ifdef INTERSECTION_FLASH_EN
    logic flash_req = 1'b0;
`endif
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic walk_ns, walk_ew, ped_ack_ns, ped_ack_ew;
    logic [5:0] lamps;

    int compareCount = 0;
    int failCount = 0;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    always #5 clk = ~clk;

    intersection_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
`ifdef INTERSECTION_FLASH_EN
        .flash_req  (flash_req),
`endif
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .ped_ack_ns (ped_ack_ns),
        .ped_ack_ew (ped_ack_ew)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs, then moves to 1 time unit past the next rising edge.
    task automatic applyStimulus(input logic reqNs, input logic reqEw, input logic en);
        ped_req_ns = reqNs;
        ped_req_ew = reqEw;
        enable     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
    endtask

    function automatic logic [5:0] nominalLamps(input int c);
        if (c < 4)       return ALL_RED;
        else if (c < 24) return NS_GREEN;
        else if (c < 31) return NS_YELLOW;
        else if (c < 35) return ALL_RED;
        else if (c < 55) return EW_GREEN;
        else if (c < 62) return EW_YELLOW;
        else             return ALL_RED;
    endfunction

    function automatic logic [5:0] earlyLamps(input int c);
        if (c < 4)       return ALL_RED;
        else if (c < 12) return NS_GREEN;
        else if (c < 19) return NS_YELLOW;
        else if (c < 23) return ALL_RED;
        else             return EW_GREEN;
    endfunction

    initial begin
        $display("[TB] reset state and nominal 62-cycle period");
        applyReset();
        checkOutput("rst_lamps", 32'(lamps), 32'(ALL_RED));
        checkOutput("rst_walk_ack", 32'({walk_ns, walk_ew, ped_ack_ns, ped_ack_ew}), 32'(0));
        for (int c = 0; c <= 62; c++) begin
            checkOutput($sformatf("nominal_c%0d", c), 32'(lamps), 32'(nominalLamps(c)));
            if (c < 62) applyStimulus(1'b0, 1'b0, 1'b1);
        end

        $display("[TB] NS walk plus EW request shortening NS green");
        applyReset();
        for (int c = 0; c <= 30; c++) begin
            checkOutput($sformatf("early_lamps_c%0d", c), 32'(lamps), 32'(earlyLamps(c)));
            checkOutput($sformatf("walk_ns_c%0d", c), 32'(walk_ns), 32'(c >= 4 && c <= 9));
            checkOutput($sformatf("ack_ns_c%0d", c), 32'(ped_ack_ns), 32'(c == 4));
            checkOutput($sformatf("walk_ew_c%0d", c), 32'(walk_ew), 32'(c >= 23 && c <= 28));
            checkOutput($sformatf("ack_ew_c%0d", c), 32'(ped_ack_ew), 32'(c == 23));
            applyStimulus(logic'(c == 1), logic'(c == 6), 1'b1);
        end

        $display("[TB] late EW request ends NS green on the following edge");
        applyReset();
        for (int c = 0; c <= 18; c++) begin
            checkOutput($sformatf("late_c%0d", c), 32'(lamps),
                        32'((c < 4) ? ALL_RED : (c < 18) ? NS_GREEN : NS_YELLOW));
            if (c < 18) applyStimulus(1'b0, logic'(c == 16), 1'b1);
        end

        $display("[TB] enable freeze during NS green");
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("frz_entry_lamps", 32'(lamps), 32'(NS_GREEN));
        checkOutput("frz_entry_ack", 32'(ped_ack_ns), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("frz_ack_drop", 32'(ped_ack_ns), 32'(0));
        checkOutput("frz_walk_hold", 32'(walk_ns), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("frz_walk_cnt5", 32'(walk_ns), 32'(1));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("frz_hold_%0d", k), 32'({lamps, walk_ns}), 32'({NS_GREEN, 1'b1}));
        end
        for (int k = 0; k <= 14; k++) begin
            checkOutput($sformatf("frz_green_%0d", k), 32'(lamps), 32'(NS_GREEN));
            if (k <= 1) checkOutput($sformatf("frz_walk_%0d", k), 32'(walk_ns), 32'(k == 0));
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("frz_yellow", 32'(lamps), 32'(NS_YELLOW));

        $display("[TB] mid-run reset clears pending NS request");
        applyReset();
        for (int c = 0; c < 56; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mrst_c56", 32'(lamps), 32'(EW_YELLOW));
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("mrst_c57", 32'(lamps), 32'(EW_YELLOW));
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        checkOutput("mrst_lamps", 32'(lamps), 32'(ALL_RED));
        checkOutput("mrst_walk_ack", 32'({walk_ns, walk_ew, ped_ack_ns, ped_ack_ew}), 32'(0));
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mrst_c3", 32'(lamps), 32'(ALL_RED));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mrst_c4", 32'(lamps), 32'(NS_GREEN));
        checkOutput("mrst_no_walk", 32'({walk_ns, ped_ack_ns}), 32'(0));

`ifdef INTERSECTION_FLASH_EN
        $display("[TB] flash mode from EW green");
        applyReset();
        for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fl_pre", 32'(lamps), 32'(EW_GREEN));
        flash_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("fl_lamps_%0d", k), 32'(lamps), 32'((k < 4) ? 6'b010_010 : 6'b000_000));
            checkOutput($sformatf("fl_walk_%0d", k), 32'({walk_ns, walk_ew}), 32'(0));
            if (k < 7) applyStimulus(1'b0, 1'b0, 1'b1);
        end
        flash_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("fl_clr_%0d", k), 32'(lamps), 32'(ALL_RED));
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("fl_ns_green", 32'(lamps), 32'(NS_GREEN));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
